// File: rtl/serial_sub_8bit_if.sv
// serial_sub_8bit_if: operand/result handshake bundle for the bit-serial subtractor
interface serial_sub_8bit_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;
  modport master (output in_valid, x, y, bi, out_ready, input in_ready, out_valid, d, bo, ovf);
  modport slave  (input in_valid, x, y, bi, out_ready, output in_ready, out_valid, d, bo, ovf);
endinterface

// File: rtl/serial_sub_8bit.sv
// serial_sub_8bit: bit-serial x - y - bi, one full-adder slice per cycle, LSB first
module serial_sub_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_sub_8bit_if.slave bus,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] xr, yr, dr;
  logic             bor, ovr;
  logic             a, b, s, co, last;
  always_comb begin
    a    = xr[cnt];
    b    = ~yr[cnt];
    s    = a ^ b ^ carry;
    co   = (a & b) | (a & carry) | (b & carry);
    last = cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      xr    <= '0;
      yr    <= '0;
      dr    <= '0;
      bor   <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          xr    <= bus.x;
          yr    <= bus.y;
          carry <= ~bus.bi;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          dr[cnt] <= s;
          carry   <= co;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            bor   <= ~co;
            ovr   <= (xr[WIDTH-1] != yr[WIDTH-1]) & (s != xr[WIDTH-1]);
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.d         = dr;
  assign bus.bo        = bor;
  assign bus.ovf       = ovr;
  assign busy          = state == RUN;
endmodule

// File: doc/serial_sub_8bit.md
SERIAL_SUB_8BIT -- requirements
Module: serial_sub_8bit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set x, y, bi is valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port x  input  WIDTH  minuend.
REQ-007 SHALL have port y  input  WIDTH  subtrahend.
REQ-008 SHALL have port bi  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port d  output  WIDTH  difference, x - y - bi mod 2^WIDTH.
REQ-012 SHALL have port bo  output  1  borrow-out: 1 iff unsigned x < y + bi.
REQ-013 SHALL have port ovf  output  1  two's-complement overflow of the signed subtraction.
REQ-014 SHALL have port busy  output  1  high while state is RUN.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE, with a bit counter of width clog2(WIDTH).
REQ-016 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-017 SHALL define accept as in_valid & in_ready at a clock edge; on accept, it captures x, y and bi into internal registers, clears the counter to 0 and enters RUN.
REQ-018 SHALL ignore changes on x, y and bi after accept until the next accept.
REQ-019 SHALL process one bit per RUN edge, LSB first, using a single full-adder slice: a = x[cnt], b = ~y[cnt], cin = carry register; the carry register is initialised to ~bi at accept.
REQ-020 SHALL write sum into d[cnt] and the slice carry-out into the carry register each RUN edge, then increment cnt.
REQ-021 SHALL, on the RUN edge with cnt = WIDTH-1, enter DONE and set bo = ~carry_out_of_msb and ovf = (x[MSB] != y[MSB]) & (d[MSB] != x[MSB]).
REQ-022 SHALL have a latency of exactly WIDTH cycles: out_valid is high in the cycle following the WIDTH-th rising edge after the accept edge (8 for the default).
REQ-023 SHALL hold d, bo and ovf stable in DONE while out_ready = 0, for any number of cycles.
REQ-024 SHALL, on a DONE edge with out_ready = 1, return to IDLE; in_ready rises in the following cycle, and there is no same-cycle result-pop/operand-accept.
REQ-025 SHALL keep d, bo and ovf at their last values in IDLE and RUN, and shall not treat them as valid unless out_valid = 1.
REQ-026 SHALL keep the IDLE->RUN->DONE->IDLE sequence and accept behaviour the same for all operand values, including y = 0, x = y, and bi = 1 with x = y.
REQ-027 SHALL ignore in_valid outside IDLE, with no queuing.

Reset
REQ-028 SHALL, when rst_n = 0 at a clock edge, set state IDLE, cnt 0, carry 0, d 0, bo 0, ovf 0, out_valid 0, busy 0 and in_ready 1 in the following cycle.
REQ-029 SHALL give reset priority over all other inputs; reset in RUN or DONE aborts the operation and discards the result, with no out_valid pulse.
REQ-030 SHALL permit a new accept on the first edge with rst_n = 1 after reset.

Verification
REQ-031 SHALL be covered by a bench scenario: x=0x05, y=0x03, bi=0, out_ready=1 -> d=0x02, bo=0, ovf=0, out_valid exactly 8 cycles after accept edge.
REQ-032 SHALL be covered by a bench scenario: x=0x00, y=0x01, bi=0 -> d=0xFF, bo=1, ovf=0; and x=0x10, y=0x10, bi=1 -> d=0xFF, bo=1, ovf=0.
REQ-033 SHALL be covered by a bench scenario: x=0x80, y=0x01, bi=0 -> d=0x7F, bo=0, ovf=1; and x=0x7F, y=0xFF, bi=0 -> d=0x80, bo=1, ovf=1.
REQ-034 SHALL be covered by a bench scenario: out_ready held 0 for 5 cycles in DONE -> out_valid, d, bo and ovf stable all 5 cycles and in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 SHALL be covered by a bench scenario: change x and y and pulse in_valid during RUN -> result reflects the captured operands and no second operation starts.
REQ-036 SHALL be covered by a bench scenario: rst_n=0 for 1 cycle at cnt=4 -> next cycle in IDLE with all outputs at their reset values and no out_valid; a fresh accept of x=0x05, y=0x03 then yields d=0x02.
